lumped_tune_sequencer: RTL and testbench

//  Sequencer and arbiter for a switched lumped-element tuning bank: CODE_W

---
 rtl/lumped_tune_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lumped_tune_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lumped_tune_sequencer.sv
// ---------------------------------------------------------------------------
// lumped_tune_sequencer
//
// Sequencer and round-robin arbiter for a switched lumped-element tuning bank.
// The bank has CODE_W binary-weighted C/L cells, and each cell has one switch
// enable. Requesters A and B submit target codes over valid/ready. The block
// applies every code change break-before-make:
//   1. cells that are being removed open first;
//   2. a dead time of BBM_CYC cycles elapses;
//   3. cells that are being added close;
//   4. a settle wait of SETTLE_CYC cycles elapses;
//   5. the granted requester receives a one-cycle ready pulse.
//
// Ports
//   clk      in   1       clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   a_valid  in   1       requester A request pending
//   a_code   in   CODE_W  requester A target code
//   a_ready  out  1       requester A completion pulse
//   b_valid  in   1       requester B request pending
//   b_code   in   CODE_W  requester B target code
//   b_ready  out  1       requester B completion pulse
//   sw_en    out  CODE_W  registered switch enables to the bank
//   busy     out  1       high whenever the sequencer is not idle
//   grant_b  out  1       owner of the current operation (0=A, 1=B)
// ---------------------------------------------------------------------------
module lumped_tune_sequencer #(
  parameter int                CODE_W     = 8,
  parameter int                BBM_CYC    = 4,
  parameter int                SETTLE_CYC = 16,
  parameter int                CNT_W      = 8,
  parameter logic [CODE_W-1:0] RESET_CODE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [CODE_W-1:0] a_code,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [CODE_W-1:0] b_code,
  output logic              b_ready,
  output logic [CODE_W-1:0] sw_en,
  output logic              busy,
  output logic              grant_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Timers are loaded with N-1 and count down to zero, so each wait state
  // lasts exactly N cycles.
  localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  timer_q,   timer_d;
  logic [CODE_W-1:0] sw_en_q,   sw_en_d;
  logic [CODE_W-1:0] tgt_q,     tgt_d;
  logic              grant_b_q, grant_b_d;
  logic              pref_b_q,  pref_b_d;
  logic              a_ready_q, a_ready_d;
  logic              b_ready_q, b_ready_d;
  logic              busy_q,    busy_d;

  logic              pick_b;
  logic [CODE_W-1:0] code_sel;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sw_en_d   = sw_en_q;
    tgt_d     = tgt_q;
    grant_b_d = grant_b_q;
    pref_b_d  = pref_b_q;
    a_ready_d = 1'b0;
    b_ready_d = 1'b0;
    // B wins when it is the only requester, or when both request and B is
    // the preferred requester.
    pick_b    = b_valid && (!a_valid || pref_b_q);
    code_sel  = pick_b ? b_code : a_code;

    unique case (state_q)
      IDLE: begin
        if (a_valid || b_valid) begin
          tgt_d     = code_sel;
          grant_b_d = pick_b;
          if ((sw_en_q & ~code_sel) != '0) begin
            // Open only the cells that must go. No cell closes on this edge.
            sw_en_d = sw_en_q & code_sel;
            timer_d = BBM_LOAD;
            state_d = BREAK;
          end else if (code_sel != sw_en_q) begin
            // This change only adds cells, so no dead time is needed.
            sw_en_d = code_sel;
            timer_d = SETTLE_LOAD;
            state_d = SETTLE;
          end else begin
            state_d   = DONE;
            a_ready_d = !pick_b;
            b_ready_d = pick_b;
          end
        end
      end
      BREAK: begin
        if (timer_q == '0) begin
          // Every remaining bit of sw_en_q is already set in tgt_q, so this
          // edge can only close cells.
          sw_en_d = tgt_q;
          timer_d = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d   = DONE;
          a_ready_d = !grant_b_q;
          b_ready_d = grant_b_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      DONE: begin
        pref_b_d = !grant_b_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sw_en_q   <= RESET_CODE;
      tgt_q     <= RESET_CODE;
      grant_b_q <= 1'b0;
      pref_b_q  <= 1'b0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sw_en_q   <= sw_en_d;
      tgt_q     <= tgt_d;
      grant_b_q <= grant_b_d;
      pref_b_q  <= pref_b_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign sw_en   = sw_en_q;
  assign a_ready = a_ready_q;
  assign b_ready = b_ready_q;
  assign busy    = busy_q;
  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_lumped_tune_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lumped_tune_sequencer
//
// Directed bench for lumped_tune_sequencer with the default parameters
// (CODE_W=8, BBM_CYC=4, SETTLE_CYC=16). Expected latencies are counted from
// the IDLE cycle in which the request is granted (cycle 0):
//   break needed : 1+4+16 = 21
//   add only     : 1+16   = 17
//   unchanged    : 1
// ---------------------------------------------------------------------------
module tb_lumped_tune_sequencer;

  localparam int MAXC = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_valid = 1'b0;
  logic [7:0] a_code = 8'h00;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [7:0] b_code = 8'h00;
  logic       b_ready;
  logic [7:0] sw_en;
  logic       busy;
  logic       grant_b;

  int checks = 0;
  int errors = 0;
  int wrong_rdy = 0;
  int bbm_viol = 0;
  int lat;
  logic [7:0] sw_hist [0:MAXC];
  logic [7:0] prev_sw = 8'h00;

  lumped_tune_sequencer #(
    .CODE_W(8), .BBM_CYC(4), .SETTLE_CYC(16), .CNT_W(8), .RESET_CODE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_code(a_code), .a_ready(a_ready),
    .b_valid(b_valid), .b_code(b_code), .b_ready(b_ready),
    .sw_en(sw_en), .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  // Flag any sampled edge where one cell closes while another opens.
  always @(posedge clk) begin
    #1;
    if (rst_n && ((~prev_sw & sw_en) != 8'h00) && ((prev_sw & ~sw_en) != 8'h00))
      bbm_viol++;
    prev_sw = sw_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request and wait a bounded number of cycles for its ready pulse.
  // drop_at > 0 deasserts valid and scrambles the code at that cycle.
  task automatic run_req(input bit use_b, input logic [7:0] code,
                         input int drop_at, output int lat_o);
    lat_o = -1;
    if (use_b) begin b_valid = 1'b1; b_code = code; end
    else       begin a_valid = 1'b1; a_code = code; end
    for (int n = 1; n <= MAXC; n++) begin
      @(posedge clk); #1;
      sw_hist[n] = sw_en;
      if (n == drop_at) begin
        if (use_b) begin b_valid = 1'b0; b_code = 8'h55; end
        else       begin a_valid = 1'b0; a_code = 8'h55; end
      end
      if (use_b ? a_ready : b_ready) wrong_rdy++;
      if (use_b ? b_ready : a_ready) begin
        lat_o = n;
        if (use_b) b_valid = 1'b0; else a_valid = 1'b0;
        break;
      end
    end
  endtask

  // Step from the DONE cycle into the following IDLE cycle.
  task automatic step_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, {a_ready, b_ready}, 0);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw_en", sw_en, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    chk("rst_grant_b", grant_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: A requests 0F from 00, which adds cells only
    run_req(1'b0, 8'h0F, 0, lat);
    chk("t1_edge1_sw", sw_hist[1], 8'h0F);
    chk("t1_lat", lat, 17);
    chk("t1_grant_b", grant_b, 0);
    step_idle("t1_after");

    // 2: B requests F0 from 0F, which needs a break first
    run_req(1'b1, 8'hF0, 0, lat);
    chk("t2_break_c1", sw_hist[1], 8'h00);
    chk("t2_break_c4", sw_hist[4], 8'h00);
    chk("t2_make_c5", sw_hist[5], 8'hF0);
    chk("t2_lat", lat, 21);
    chk("t2_grant_b", grant_b, 1);
    step_idle("t2_after");

    // 3: both request with A preferred; A re-requests right after its ready
    b_code = 8'hFF; b_valid = 1'b1;
    run_req(1'b0, 8'h3C, 0, lat);
    chk("t3_a_lat", lat, 21);
    chk("t3_a_grant", grant_b, 0);
    a_valid = 1'b1; a_code = 8'h3C;
    step_idle("t3_idle1");
    run_req(1'b1, 8'hFF, 0, lat);          // contention: B now preferred
    chk("t3_b_sw", sw_hist[1], 8'hFF);
    chk("t3_b_lat", lat, 17);
    chk("t3_b_grant", grant_b, 1);
    step_idle("t3_idle2");
    run_req(1'b0, 8'h3C, 0, lat);
    chk("t3_a2_break", sw_hist[1], 8'h3C);
    chk("t3_a2_lat", lat, 21);
    chk("t3_a2_grant", grant_b, 0);
    step_idle("t3_idle3");

    // 4: unchanged code
    run_req(1'b0, 8'h3C, 0, lat);
    chk("t4_sw", sw_hist[1], 8'h3C);
    chk("t4_lat", lat, 1);
    step_idle("t4_after");

    // 5: reset during SETTLE of an FF request
    a_valid = 1'b1; a_code = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_settle_busy", busy, 1);
    chk("t5_settle_sw", sw_en, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sw", sw_en, 8'h00);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdy", {a_ready, b_ready}, 0);
    a_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_rel_busy", busy, 0);
    chk("t5_rel_rdy", {a_ready, b_ready}, 0);
    b_code = 8'h02; b_valid = 1'b1;
    run_req(1'b0, 8'h01, 0, lat);          // A must win after reset
    chk("t5_a_sw", sw_hist[1], 8'h01);
    chk("t5_a_lat", lat, 17);
    chk("t5_a_grant", grant_b, 0);
    step_idle("t5_idle");
    run_req(1'b1, 8'h02, 0, lat);
    chk("t5_b_break", sw_hist[1], 8'h00);
    chk("t5_b_make", sw_hist[5], 8'h02);
    chk("t5_b_lat", lat, 21);
    step_idle("t5_after");

    // 6: A drops valid during BREAK and changes its code after the grant
    run_req(1'b0, 8'h81, 2, lat);
    chk("t6_break", sw_hist[1], 8'h00);
    chk("t6_make", sw_hist[5], 8'h81);
    chk("t6_lat", lat, 21);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t6_no_repeat", {a_ready, busy}, 0);
    end
    chk("t6_final_sw", sw_en, 8'h81);

    chk("bbm_overlap", bbm_viol, 0);
    chk("wrong_ready", wrong_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
